// File: rtl/microwave_pkg.sv
// Shared encodings and timing defaults for the
// microwave front-panel keypad controller.
package microwave_pkg;

  localparam int CODE_W = 4;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_STROBE_DELAY = 8;
  localparam int DEF_STROBE_LEN   = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_DELAY    = 3'd2;
  localparam logic [2:0] ST_STROBE   = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    DEBOUNCE = ST_DEBOUNCE,
    DELAY    = ST_DELAY,
    STROBE   = ST_STROBE,
    RELEASE  = ST_RELEASE
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit encoder for the raw key lines;
// lowest index wins when several keys are down.
module key_prio_enc
  import microwave_pkg::*;
#(
  parameter int NKEYS = 10
) (
  input  logic [NKEYS-1:0]  key,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  always_comb begin
    code = '0;
    any  = |key;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (key[i]) begin
        code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/keypad_encoder_ctrl.sv
// Keypad sequencer: pick, debounce, settle, strobe
// the key code, then wait for a stable release.
module keypad_encoder_ctrl
  import microwave_pkg::*;
#(
  parameter int NKEYS        = 10,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int STROBE_DELAY = DEF_STROBE_DELAY,
  parameter int STROBE_LEN   = DEF_STROBE_LEN
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NKEYS-1:0]  key,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              busy
);

  localparam int CNT_MAX =
    max3(DEB_CYCLES, STROBE_DELAY, STROBE_LEN);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST =
    CW'(STROBE_DELAY - 1);
  localparam logic [CW-1:0] LEN_LAST =
    CW'(STROBE_LEN - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CODE_W-1:0]  idx;
  logic [NKEYS-1:0]   key_q;
  logic [CODE_W-1:0]  enc_code;
  logic               any;

  key_prio_enc #(
    .NKEYS(NKEYS)
  ) u_enc (
    .key (key_q),
    .code(enc_code),
    .any (any)
  );

  // valid/busy are set on the transition edge so
  // they are registered copies of the state.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      key_q <= '0;
      code  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      key_q <= key;
      unique case (state)
        IDLE: begin
          if (any) begin
            idx   <= enc_code;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!key_q[idx]) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= DELAY;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DELAY: begin
          if (cnt == DLY_LAST) begin
            cnt   <= '0;
            code  <= idx;
            state <= STROBE;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        STROBE: begin
          if (cnt == LEN_LAST) begin
            cnt   <= '0;
            state <= RELEASE;
            valid <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RELEASE: begin
          if (any) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
